// File: rtl/tour_solver_gen.sv
// tour_solver_gen
//   Open knight's tour search on a BOARD_W x BOARD_H board by depth-first
//   backtracking over the 8 knight moves, starting from a given square.
//   After a successful search the move list is read out combinationally.
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset
//   go              start pulse, accepted only in IDLE/DONE/FAIL
//   x_start/y_start start square, captured with an accepted go
//   indx            readout index into the solved move list
//   move            one-hot move taken from step indx to indx+1 (8'h00 past the end)
//   busy            search in progress
//   done            tour found (held until next accepted go or rst)
//   fail            no tour exists or start square off the board (held likewise)
//   update_position 1-cycle pulse for every square placement
//   dbg_state       current FSM state, for checkers and debug
//
// Move encoding (dx,dy): b0(+1,+2) b1(-1,+2) b2(-2,+1) b3(-2,-1)
//                        b4(-1,-2) b5(+1,-2) b6(+2,-1) b7(+2,+1)
module tour_solver_gen #(
    parameter int BOARD_W = 5,
    parameter int BOARD_H = 5,
    parameter int COORD_W = 3,
    parameter int STEP_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [COORD_W-1:0] x_start,
    input  logic [COORD_W-1:0] y_start,
    input  logic [STEP_W-1:0]  indx,
    output logic [7:0]         move,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic               update_position,
    output logic [2:0]         dbg_state
);

    localparam int NSQ = BOARD_W * BOARD_H;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSQ - 1);

    // Two extra bits so that x-2 and x+2 never wrap.
    typedef logic signed [COORD_W+1:0] scoord_t;
    localparam scoord_t SW = scoord_t'(BOARD_W);
    localparam scoord_t SH = scoord_t'(BOARD_H);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INIT      = 3'd1,
        PLACE     = 3'd2,
        POSSIBLE  = 3'd3,
        MAKE_MOVE = 3'd4,
        BACKUP    = 3'd5,
        DONE      = 3'd6,
        FAIL      = 3'd7
    } state_t;

    function automatic scoord_t move_dx(input logic [2:0] k);
        case (k)
            3'd0, 3'd5: move_dx = scoord_t'(1);
            3'd1, 3'd4: move_dx = scoord_t'(-1);
            3'd2, 3'd3: move_dx = scoord_t'(-2);
            default:    move_dx = scoord_t'(2);
        endcase
    endfunction

    function automatic scoord_t move_dy(input logic [2:0] k);
        case (k)
            3'd0, 3'd1: move_dy = scoord_t'(2);
            3'd2, 3'd7: move_dy = scoord_t'(1);
            3'd3, 3'd6: move_dy = scoord_t'(-1);
            default:    move_dy = scoord_t'(-2);
        endcase
    endfunction

    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        oh2idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (oh[k]) oh2idx = 3'(k);
        end
    endfunction

    state_t              state_q, state_d;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [7:0]          try_q, try_d;

    // board: 0 = unvisited, otherwise step+1 of the visit
    logic [STEP_W:0]     board_q [BOARD_W][BOARD_H];
    logic [7:0]          poss_q  [NSQ];
    logic [7:0]          last_q  [NSQ];

    logic                board_clr, board_we, poss_we, last_we;
    logic [STEP_W:0]     board_wdata;
    logic [7:0]          legal;
    logic [7:0]          prev_mv;
    scoord_t             tx, ty, nx, ny;
    logic                start_ok;

    // Legal-move mask at the current square.
    always_comb begin
        legal = '0;
        tx    = '0;
        ty    = '0;
        for (int k = 0; k < 8; k++) begin
            tx = $signed({2'b00, x_q}) + move_dx(3'(k));
            ty = $signed({2'b00, y_q}) + move_dy(3'(k));
            if (tx >= 0 && tx < SW && ty >= 0 && ty < SH) begin
                legal[k] = (board_q[tx[COORD_W-1:0]][ty[COORD_W-1:0]] == '0);
            end
        end
    end

    assign start_ok = (32'(x_start) < BOARD_W) && (32'(y_start) < BOARD_H);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        step_d      = step_q;
        try_d       = try_q;
        board_clr   = 1'b0;
        board_we    = 1'b0;
        board_wdata = '0;
        poss_we     = 1'b0;
        last_we     = 1'b0;
        prev_mv     = '0;
        nx          = '0;
        ny          = '0;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (go) begin
                    if (start_ok) begin
                        state_d = INIT;
                        x_d     = x_start;
                        y_d     = y_start;
                    end else begin
                        state_d = FAIL;
                    end
                end
            end
            INIT: begin
                board_clr = 1'b1;
                step_d    = '0;
                state_d   = PLACE;
            end
            PLACE: begin
                board_we    = 1'b1;
                board_wdata = {1'b0, step_q} + 1'b1;
                state_d     = (step_q == LAST_STEP) ? DONE : POSSIBLE;
            end
            POSSIBLE: begin
                poss_we = 1'b1;
                try_d   = 8'h01;
                state_d = MAKE_MOVE;
            end
            MAKE_MOVE: begin
                if ((poss_q[step_q] & try_q) != 8'h00) begin
                    last_we = 1'b1;
                    nx      = $signed({2'b00, x_q}) + move_dx(oh2idx(try_q));
                    ny      = $signed({2'b00, y_q}) + move_dy(oh2idx(try_q));
                    x_d     = nx[COORD_W-1:0];
                    y_d     = ny[COORD_W-1:0];
                    step_d  = step_q + 1'b1;
                    state_d = PLACE;
                end else if (try_q == 8'h80) begin
                    state_d = BACKUP;
                end else begin
                    try_d = try_q << 1;
                end
            end
            BACKUP: begin
                if (step_q == '0) begin
                    // Start square stays marked; the whole tree is exhausted.
                    state_d = FAIL;
                end else begin
                    prev_mv  = last_q[step_q - 1'b1];
                    board_we = 1'b1;
                    nx       = $signed({2'b00, x_q}) - move_dx(oh2idx(prev_mv));
                    ny       = $signed({2'b00, y_q}) - move_dy(oh2idx(prev_mv));
                    x_d      = nx[COORD_W-1:0];
                    y_d      = ny[COORD_W-1:0];
                    step_d   = step_q - 1'b1;
                    if (prev_mv == 8'h80) begin
                        state_d = BACKUP;
                    end else begin
                        try_d   = prev_mv << 1;
                        state_d = MAKE_MOVE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Search storage is not reset; INIT clears the board before every run.
    always_ff @(posedge clk) begin
        x_q    <= x_d;
        y_q    <= y_d;
        step_q <= step_d;
        try_q  <= try_d;
        if (board_clr) begin
            for (int i = 0; i < BOARD_W; i++) begin
                for (int j = 0; j < BOARD_H; j++) begin
                    board_q[i][j] <= '0;
                end
            end
        end else if (board_we) begin
            board_q[x_q][y_q] <= board_wdata;
        end
        if (poss_we) poss_q[step_q] <= legal;
        if (last_we) last_q[step_q] <= try_q;
    end

    always_comb begin
        move = 8'h00;
        if (indx < LAST_STEP) move = last_q[indx];
    end

    assign busy            = (state_q != IDLE) && (state_q != DONE) && (state_q != FAIL);
    assign done            = (state_q == DONE);
    assign fail            = (state_q == FAIL);
    assign update_position = (state_q == PLACE);
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_tour_solver_gen.sv
module tb_tour_solver_gen;

    localparam logic [2:0] S_IDLE = 3'd0, S_INIT = 3'd1, S_BACKUP = 3'd5,
                           S_DONE = 3'd6, S_FAIL = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 5x5 instance
    logic       go5 = 1'b0;
    logic [2:0] xs5 = '0, ys5 = '0;
    logic [4:0] indx5 = '0;
    logic [7:0] move5;
    logic       busy5, done5, fail5, up5;
    logic [2:0] st5;

    // 3x3 instance
    logic       go3 = 1'b0;
    logic [1:0] xs3 = '0, ys3 = '0;
    logic [3:0] indx3 = '0;
    logic [7:0] move3;
    logic       busy3, done3, fail3, up3;
    logic [2:0] st3;

    // 4 wide x 3 high instance
    logic       go43 = 1'b0;
    logic [1:0] xs43 = '0, ys43 = '0;
    logic [3:0] indx43 = '0;
    logic [7:0] move43;
    logic       busy43, done43, fail43, up43;
    logic [2:0] st43;

    tour_solver_gen #(.BOARD_W(5), .BOARD_H(5), .COORD_W(3), .STEP_W(5)) d5 (
        .clk(clk), .rst(rst), .go(go5), .x_start(xs5), .y_start(ys5), .indx(indx5),
        .move(move5), .busy(busy5), .done(done5), .fail(fail5),
        .update_position(up5), .dbg_state(st5));

    tour_solver_gen #(.BOARD_W(3), .BOARD_H(3), .COORD_W(2), .STEP_W(4)) d3 (
        .clk(clk), .rst(rst), .go(go3), .x_start(xs3), .y_start(ys3), .indx(indx3),
        .move(move3), .busy(busy3), .done(done3), .fail(fail3),
        .update_position(up3), .dbg_state(st3));

    tour_solver_gen #(.BOARD_W(4), .BOARD_H(3), .COORD_W(2), .STEP_W(4)) d43 (
        .clk(clk), .rst(rst), .go(go43), .x_start(xs43), .y_start(ys43), .indx(indx43),
        .move(move43), .busy(busy43), .done(done43), .fail(fail43),
        .update_position(up43), .dbg_state(st43));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each go task returns 1 time unit after the edge that sampled go.
    task automatic pulse_go5(input logic [2:0] x, input logic [2:0] y);
        xs5 = x; ys5 = y; go5 = 1'b1;
        @(posedge clk); #1;
        go5 = 1'b0;
    endtask

    task automatic pulse_go3(input logic [1:0] x, input logic [1:0] y);
        xs3 = x; ys3 = y; go3 = 1'b1;
        @(posedge clk); #1;
        go3 = 1'b0;
    endtask

    task automatic pulse_go43(input logic [1:0] x, input logic [1:0] y);
        xs43 = x; ys43 = y; go43 = 1'b1;
        @(posedge clk); #1;
        go43 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int cyc, ups, bks, nz, overlap;
        int px, py, nxp, nyp, k, nvis, bad_oh, off, revisit;
        logic [7:0] mv;
        logic vis [4][3];
        int dxt [8];
        int dyt [8];
        dxt = '{1, -1, -2, -2, -1, 1, 2, 2};
        dyt = '{2, 2, 1, -1, -2, -2, -1, 1};
        overlap = 0;

        // ---------------- reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy5, 0);
        check("rst_done", done5, 0);
        check("rst_fail", fail5, 0);
        check("rst_upd",  up5, 0);
        check("rst_state", st5, S_IDLE);
        rst = 1'b0;

        // ---------------- 5x5 start column out of range
        pulse_go5(3'd5, 3'd0);
        check("oob5_fail", fail5, 1);
        check("oob5_busy", busy5, 0);
        check("oob5_done", done5, 0);
        check("oob5_upd",  up5, 0);
        @(posedge clk); #1;
        check("oob5_hold", fail5, 1);
        check("oob5_busy2", busy5, 0);

        // ---------------- accepted go from FAIL, ignored go, rst mid-solve
        pulse_go5(3'd4, 3'd4);
        check("acc5_state", st5, S_INIT);
        check("acc5_busy", busy5, 1);
        check("acc5_fail", fail5, 0);
        check("acc5_done", done5, 0);
        repeat (5) @(posedge clk);
        #1;
        pulse_go5(3'd0, 3'd0);
        check("ign5_not_init", (st5 == S_INIT), 0);
        check("ign5_busy", busy5, 1);
        do_reset();
        check("mid_rst_busy", busy5, 0);
        check("mid_rst_done", done5, 0);
        check("mid_rst_fail", fail5, 0);
        check("mid_rst_state", st5, S_IDLE);

        // ---------------- 3x3 start row out of range, from IDLE
        pulse_go3(2'd0, 2'd3);
        check("oob3_fail", fail3, 1);
        check("oob3_busy", busy3, 0);

        // ---------------- 3x3 from centre: no move possible, fail after 12 clocks
        pulse_go3(2'd1, 2'd1);
        check("c3_fail_clr", fail3, 0);
        check("c3_busy", busy3, 1);
        cyc = 0; ups = 0;
        while (!fail3 && !done3 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (up3) ups++;
            if (busy3 && (done3 || fail3)) overlap++;
        end
        check("c3_latency", cyc, 12);
        check("c3_fail", fail3, 1);
        check("c3_done", done3, 0);
        check("c3_busy_off", busy3, 0);
        check("c3_ups", ups, 1);
        check("c3_start_sq", d3.board_q[1][1], 1);

        // ---------------- 3x3 from corner: exhaustive search, no tour
        pulse_go3(2'd0, 2'd0);
        cyc = 0;
        while (!fail3 && !done3 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (busy3 && (done3 || fail3)) overlap++;
        end
        check("k3_fail", fail3, 1);
        check("k3_done", done3, 0);
        nz = 0;
        for (int ix = 0; ix < 3; ix++) begin
            for (int iy = 0; iy < 3; iy++) begin
                if (!(ix == 0 && iy == 0) && d3.board_q[ix][iy] != 0) nz++;
            end
        end
        check("k3_board_clear", nz, 0);
        check("k3_start_sq", d3.board_q[0][0], 1);

        // ---------------- 4x3: ignored go while busy, rst mid-solve, then full solve
        pulse_go43(2'd0, 2'd0);
        check("s43_busy", busy43, 1);
        repeat (4) @(posedge clk);
        #1;
        pulse_go43(2'd1, 2'd1);
        check("ign43_not_init", (st43 == S_INIT), 0);
        check("ign43_busy", busy43, 1);
        do_reset();
        check("rst43_state", st43, S_IDLE);
        check("rst43_busy", busy43, 0);

        pulse_go43(2'd0, 2'd0);
        cyc = 0; ups = 0; bks = 0;
        while (!done43 && !fail43 && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            if (up43) ups++;
            if (st43 == S_BACKUP) bks++;
            if (busy43 && (done43 || fail43)) overlap++;
        end
        check("t43_done", done43, 1);
        check("t43_fail", fail43, 0);
        check("t43_busy", busy43, 0);
        check("t43_state", st43, S_DONE);
        check("t43_net_place", ups - bks, 12);

        // Replay the move list from the start square.
        for (int ix = 0; ix < 4; ix++)
            for (int iy = 0; iy < 3; iy++)
                vis[ix][iy] = 1'b0;
        px = 0; py = 0; vis[0][0] = 1'b1; nvis = 1;
        bad_oh = 0; off = 0; revisit = 0;
        for (int i = 0; i < 11; i++) begin
            indx43 = 4'(i);
            #1;
            mv = move43;
            if (i == 0) check("t43_move0", (mv == 8'h01 || mv == 8'h80), 1);
            if (!$onehot(mv)) begin
                bad_oh++;
            end else begin
                k = 0;
                for (int b = 0; b < 8; b++) if (mv[b]) k = b;
                nxp = px + dxt[k];
                nyp = py + dyt[k];
                if (nxp < 0 || nxp > 3 || nyp < 0 || nyp > 2) begin
                    off++;
                end else begin
                    if (vis[nxp][nyp]) revisit++;
                    else begin
                        vis[nxp][nyp] = 1'b1;
                        nvis++;
                    end
                    px = nxp; py = nyp;
                end
            end
        end
        check("t43_onehot", bad_oh, 0);
        check("t43_on_board", off, 0);
        check("t43_no_revisit", revisit, 0);
        check("t43_all_visited", nvis, 12);
        indx43 = 4'd11; #1;
        check("t43_idx_end", move43, 8'h00);
        indx43 = 4'd15; #1;
        check("t43_idx_max", move43, 8'h00);

        check("busy_with_result", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
